// File: rtl/trap_pkg.sv
// Shared constants and state type for the machine-mode trap sequencer.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   localparam logic [4:0] CAUSE_ILLEGAL_ADDR = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL_INST = 5'd2;
   localparam logic [4:0] CAUSE_EBREAK       = 5'd3;
   localparam logic [4:0] CAUSE_L_FAULT      = 5'd5;
   localparam logic [4:0] CAUSE_S_FAULT      = 5'd7;
   localparam logic [4:0] CAUSE_ECALL        = 5'd11;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MTVAL,
      REDIRECT
   } trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: the highest set bit of the pending vector wins.
module trap_prio_enc #(
   parameter  int unsigned NUM_IRQ = 12,
   localparam int unsigned IW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic [NUM_IRQ-1:0] pending,
   output logic               valid,
   output logic [IW-1:0]      index
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (pending[i]) begin
            valid = 1'b1;
            index = IW'(i);
         end
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: detects traps/mret at MEM, sequences the
// trap CSR writes through the CSR write port and redirects the PC.
module trap_sequencer
   import trap_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_IRQ     = 12,
   parameter int unsigned VECTORED_EN = 1,
   parameter int unsigned MTVAL_EN    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               exc_illegal_addr,
   input  logic               exc_illegal_inst,
   input  logic               exc_ebreak,
   input  logic               exc_l_fault,
   input  logic               exc_s_fault,
   input  logic               exc_ecall,
   input  logic [NUM_IRQ-1:0] irq_pending,
   input  logic [NUM_IRQ-1:0] csr_mie,
   input  logic [XLEN-1:0]    csr_mstatus,
   input  logic [XLEN-1:0]    csr_mtvec,
   input  logic [XLEN-1:0]    csr_mepc,
   input  logic               mret,
   input  logic [XLEN-1:0]    epc_cur,
   input  logic [XLEN-1:0]    epc_next,
   input  logic [XLEN-1:0]    bad_val,
   output logic               csr_we,
   output logic [11:0]        csr_waddr,
   output logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    pc_redirect,
   output logic               redirect_valid,
   output logic               flush_fd,
   output logic               flush_de,
   output logic               flush_em,
   output logic               flush_mw,
   output logic               regwrite_cancel,
   output logic               busy
);

   localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   trap_state_e     state;
   logic [XLEN-1:0] epc_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] tval_q;

   logic [NUM_IRQ-1:0] irq_masked;
   logic               irq_valid;
   logic [IW-1:0]      irq_idx;
   logic               take_exc;
   logic               take_irq;
   logic               trap_req;
   logic [4:0]         exc_cause;
   logic [XLEN-1:0]    irq_cause;
   logic [XLEN-1:0]    mstatus_trap;
   logic [XLEN-1:0]    mstatus_mret;
   logic [XLEN-1:0]    vec_offset;
   logic               use_vector;

   assign irq_masked = irq_pending & csr_mie;

   trap_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .pending (irq_masked),
      .valid   (irq_valid),
      .index   (irq_idx)
   );

   assign take_exc = exc_illegal_addr | exc_illegal_inst | exc_ebreak |
                     exc_l_fault | exc_s_fault | exc_ecall;
   assign take_irq = csr_mstatus[MSTATUS_MIE] & irq_valid;
   assign trap_req = take_exc | take_irq;
   assign irq_cause = {1'b1, {(XLEN-1-IW){1'b0}}, irq_idx};

   always_comb begin
      if      (exc_illegal_addr) exc_cause = CAUSE_ILLEGAL_ADDR;
      else if (exc_illegal_inst) exc_cause = CAUSE_ILLEGAL_INST;
      else if (exc_ebreak)       exc_cause = CAUSE_EBREAK;
      else if (exc_l_fault)      exc_cause = CAUSE_L_FAULT;
      else if (exc_s_fault)      exc_cause = CAUSE_S_FAULT;
      else                       exc_cause = CAUSE_ECALL;
   end

   always_comb begin
      mstatus_trap               = csr_mstatus;
      mstatus_trap[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
      mstatus_trap[MSTATUS_MIE]  = 1'b0;
      mstatus_mret               = csr_mstatus;
      mstatus_mret[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
      mstatus_mret[MSTATUS_MPIE] = 1'b1;
   end

   // Interrupt index lives in the low bits of cause_q; the MSB flags an interrupt.
   assign use_vector = (VECTORED_EN != 0) && (csr_mtvec[1:0] == 2'b01) && cause_q[XLEN-1];
   assign vec_offset = use_vector ? {cause_q[XLEN-3:0], 2'b00} : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         epc_q   <= '0;
         cause_q <= '0;
         tval_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (trap_req) begin
                  state   <= W_MEPC;
                  epc_q   <= take_exc ? epc_cur : epc_next;
                  cause_q <= take_exc ? {{(XLEN-5){1'b0}}, exc_cause} : irq_cause;
                  tval_q  <= take_exc ? bad_val : '0;
               end
            end
            W_MEPC:   state <= W_MCAUSE;
            W_MCAUSE: state <= (MTVAL_EN != 0) ? W_MTVAL : REDIRECT;
            W_MTVAL:  state <= REDIRECT;
            REDIRECT: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   always_comb begin
      csr_we          = 1'b0;
      csr_waddr       = '0;
      csr_wdata       = '0;
      pc_redirect     = '0;
      redirect_valid  = 1'b0;
      flush_fd        = 1'b0;
      flush_de        = 1'b0;
      flush_em        = 1'b0;
      flush_mw        = 1'b0;
      regwrite_cancel = 1'b0;
      busy            = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (trap_req) begin
                  csr_we          = 1'b1;
                  csr_waddr       = CSR_MSTATUS;
                  csr_wdata       = mstatus_trap;
                  flush_fd        = 1'b1;
                  flush_de        = 1'b1;
                  flush_em        = 1'b1;
                  flush_mw        = 1'b1;
                  regwrite_cancel = take_exc;
               end else if (mret) begin
                  csr_we         = 1'b1;
                  csr_waddr      = CSR_MSTATUS;
                  csr_wdata      = mstatus_mret;
                  pc_redirect    = csr_mepc;
                  redirect_valid = 1'b1;
                  flush_fd       = 1'b1;
                  flush_de       = 1'b1;
                  flush_em       = 1'b1;
               end
            end
            W_MEPC: begin
               csr_we    = 1'b1;
               csr_waddr = CSR_MEPC;
               csr_wdata = epc_q;
               flush_fd  = 1'b1;
               busy      = 1'b1;
            end
            W_MCAUSE: begin
               csr_we    = 1'b1;
               csr_waddr = CSR_MCAUSE;
               csr_wdata = cause_q;
               flush_fd  = 1'b1;
               busy      = 1'b1;
            end
            W_MTVAL: begin
               csr_we    = 1'b1;
               csr_waddr = CSR_MTVAL;
               csr_wdata = tval_q;
               flush_fd  = 1'b1;
               busy      = 1'b1;
            end
            REDIRECT: begin
               pc_redirect    = {csr_mtvec[XLEN-1:2], 2'b00} + vec_offset;
               redirect_valid = 1'b1;
               flush_fd       = 1'b1;
               busy           = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed cases plus random stimulus
// against a queue-based model of the expected per-cycle output stream.
module tb_trap_sequencer;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NUM_IRQ = 12;
   localparam int unsigned VEC_EN  = 1;
   localparam int unsigned TVAL_EN = 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               exc_illegal_addr, exc_illegal_inst, exc_ebreak;
   logic               exc_l_fault, exc_s_fault, exc_ecall;
   logic [NUM_IRQ-1:0] irq_pending, csr_mie;
   logic [XLEN-1:0]    csr_mstatus, csr_mtvec, csr_mepc;
   logic               mret;
   logic [XLEN-1:0]    epc_cur, epc_next, bad_val;
   logic               csr_we;
   logic [11:0]        csr_waddr;
   logic [XLEN-1:0]    csr_wdata, pc_redirect;
   logic               redirect_valid, flush_fd, flush_de, flush_em, flush_mw;
   logic               regwrite_cancel, busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   typedef struct {
      logic        is_redir;
      logic [11:0] addr;
      logic [31:0] data;
      logic        is_irq;
      int unsigned idx;
   } step_t;

   step_t exp_q[$];

   trap_sequencer #(
      .XLEN        (XLEN),
      .NUM_IRQ     (NUM_IRQ),
      .VECTORED_EN (VEC_EN),
      .MTVAL_EN    (TVAL_EN)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .exc_illegal_addr (exc_illegal_addr),
      .exc_illegal_inst (exc_illegal_inst),
      .exc_ebreak       (exc_ebreak),
      .exc_l_fault      (exc_l_fault),
      .exc_s_fault      (exc_s_fault),
      .exc_ecall        (exc_ecall),
      .irq_pending      (irq_pending),
      .csr_mie          (csr_mie),
      .csr_mstatus      (csr_mstatus),
      .csr_mtvec        (csr_mtvec),
      .csr_mepc         (csr_mepc),
      .mret             (mret),
      .epc_cur          (epc_cur),
      .epc_next         (epc_next),
      .bad_val          (bad_val),
      .csr_we           (csr_we),
      .csr_waddr        (csr_waddr),
      .csr_wdata        (csr_wdata),
      .pc_redirect      (pc_redirect),
      .redirect_valid   (redirect_valid),
      .flush_fd         (flush_fd),
      .flush_de         (flush_de),
      .flush_em         (flush_em),
      .flush_mw         (flush_mw),
      .regwrite_cancel  (regwrite_cancel),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic quiet();
      exc_illegal_addr = 0; exc_illegal_inst = 0; exc_ebreak = 0;
      exc_l_fault = 0; exc_s_fault = 0; exc_ecall = 0;
      irq_pending = '0; csr_mie = '0; mret = 0;
      csr_mstatus = 32'h0000_0008;
      csr_mtvec = 32'h800; csr_mepc = '0;
      epc_cur = '0; epc_next = '0; bad_val = '0;
   endtask

   // Reference: decides from the trap rules what this cycle must show and
   // queues the rest of any trap sequence it starts.
   task automatic model_check();
      logic        e_we, e_rv, e_fd, e_de, e_em, e_mw, e_cancel, e_busy;
      logic [11:0] e_addr;
      logic [31:0] e_data, e_pc, ms;
      logic        flags[6];
      int unsigned codes[6];
      logic        exc;
      logic        irq_on;
      int unsigned hi;
      logic [31:0] cause, epc, tval;
      step_t       s;
      e_we = 0; e_rv = 0; e_fd = 0; e_de = 0; e_em = 0; e_mw = 0;
      e_cancel = 0; e_busy = 0; e_addr = '0; e_data = '0; e_pc = '0;
      flags = '{exc_illegal_addr, exc_illegal_inst, exc_ebreak, exc_l_fault, exc_s_fault, exc_ecall};
      codes = '{0, 2, 3, 5, 7, 11};
      if (rst) begin
         exp_q.delete();
      end else if (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         e_busy = 1; e_fd = 1;
         if (!s.is_redir) begin
            e_we = 1; e_addr = s.addr; e_data = s.data;
         end else begin
            e_rv = 1;
            e_pc = (csr_mtvec & ~32'd3);
            if (VEC_EN == 1 && csr_mtvec[1:0] == 2'b01 && s.is_irq) e_pc = e_pc + 4 * s.idx;
         end
      end else begin
         exc = 0; cause = '0;
         for (int k = 5; k >= 0; k--) if (flags[k]) begin exc = 1; cause = codes[k]; end
         irq_on = 0; hi = 0;
         for (int unsigned i = 0; i < NUM_IRQ; i++)
            if (irq_pending[i] && csr_mie[i]) begin irq_on = csr_mstatus[3]; hi = i; end
         if (exc || irq_on) begin
            if (!exc) cause = 32'h8000_0000 + hi;
            epc  = exc ? epc_cur : epc_next;
            tval = exc ? bad_val : 32'h0;
            ms = csr_mstatus; ms[7] = csr_mstatus[3]; ms[3] = 1'b0;
            e_we = 1; e_addr = 12'h300; e_data = ms;
            e_fd = 1; e_de = 1; e_em = 1; e_mw = 1; e_cancel = exc;
            exp_q.push_back('{0, 12'h341, epc, 0, 0});
            exp_q.push_back('{0, 12'h342, cause, 0, 0});
            if (TVAL_EN == 1) exp_q.push_back('{0, 12'h343, tval, 0, 0});
            exp_q.push_back('{1, 12'h000, 32'h0, !exc, hi});
         end else if (mret) begin
            ms = csr_mstatus; ms[3] = csr_mstatus[7]; ms[7] = 1'b1;
            e_we = 1; e_addr = 12'h300; e_data = ms;
            e_rv = 1; e_pc = csr_mepc; e_fd = 1; e_de = 1; e_em = 1;
         end
      end
      check("csr_we", 32'(csr_we), 32'(e_we));
      check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
      check("busy", 32'(busy), 32'(e_busy));
      check("flushes", {28'd0, flush_fd, flush_de, flush_em, flush_mw}, {28'd0, e_fd, e_de, e_em, e_mw});
      check("regwrite_cancel", 32'(regwrite_cancel), 32'(e_cancel));
      if (e_we) begin
         check("csr_waddr", 32'(csr_waddr), 32'(e_addr));
         check("csr_wdata", csr_wdata, e_data);
      end
      if (e_rv) check("pc_redirect", pc_redirect, e_pc);
   endtask

   // Inputs are set just after a falling edge; sample, then move to the next one.
   task automatic tick();
      #1;
      model_check();
      @(negedge clk);
   endtask

   initial begin
      quiet();
      rst = 1;
      @(negedge clk);
      tick();
      check("reset_busy", 32'(busy), 32'd0);
      rst = 0;
      tick();

      // Illegal instruction trap
      exc_illegal_inst = 1; epc_cur = 32'h100; bad_val = 32'h0000_FFFF;
      tick();
      quiet();
      repeat (3) tick();
      #1 check("ill_redirect", pc_redirect, 32'h800);
      tick();
      tick();

      // Vectored interrupt, line 11 beats line 7
      irq_pending = 12'h880; csr_mie = 12'h880; csr_mtvec = 32'h801; epc_next = 32'h204;
      tick();
      quiet(); csr_mtvec = 32'h801;
      repeat (3) tick();
      #1 check("vec_redirect", pc_redirect, 32'h82C);
      tick();
      quiet();

      // ecall together with interrupt 11
      exc_ecall = 1; irq_pending = 12'h800; csr_mie = 12'h800; epc_cur = 32'h300; epc_next = 32'h304;
      tick();
      quiet();
      repeat (5) tick();

      // Masked interrupts
      irq_pending = '1; csr_mie = '1; csr_mstatus = 32'h0;
      tick();
      csr_mstatus = 32'h8; csr_mie = '0;
      tick();
      quiet();

      // mret, then mret with a same-cycle ebreak
      mret = 1; csr_mepc = 32'h104; csr_mstatus = 32'h80;
      tick();
      exc_ebreak = 1; epc_cur = 32'h110;
      tick();
      quiet();
      repeat (5) tick();

      // Reset in W_MCAUSE, then a full new trap
      exc_s_fault = 1; epc_cur = 32'h400; bad_val = 32'h1234;
      tick();
      quiet();
      tick();
      rst = 1;
      tick();
      rst = 0;
      tick();
      exc_l_fault = 1; epc_cur = 32'h500; bad_val = 32'h55;
      tick();
      quiet();
      repeat (5) tick();

      // Random traffic, inputs also toggled mid-sequence
      for (int n = 0; n < 3000; n++) begin
         exc_illegal_addr = ($urandom_range(0, 23) == 0);
         exc_illegal_inst = ($urandom_range(0, 23) == 0);
         exc_ebreak       = ($urandom_range(0, 23) == 0);
         exc_l_fault      = ($urandom_range(0, 23) == 0);
         exc_s_fault      = ($urandom_range(0, 23) == 0);
         exc_ecall        = ($urandom_range(0, 23) == 0);
         irq_pending      = NUM_IRQ'($urandom);
         csr_mie          = ($urandom_range(0, 2) == 0) ? NUM_IRQ'($urandom) : '0;
         csr_mstatus      = $urandom;
         csr_mtvec        = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
         csr_mepc         = $urandom;
         mret             = ($urandom_range(0, 3) == 0);
         epc_cur          = $urandom;
         epc_next         = $urandom;
         bad_val          = $urandom;
         rst              = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 0;
      quiet();
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Parametrised machine-mode trap controller for the pipelined RV32 core. It replaces the fixed single-interrupt exception unit with the following:
- a generic `NUM_IRQ`-wide interrupt vector with fixed priority;
- optional vectored `mtvec` dispatch;
- an optional `mtval` write.

It sits beside the CSR file. It detects exceptions and interrupts at the MEM stage, sequences the trap CSR writes through the CSR file's write port, then redirects the PC. It also produces the pipeline flush and register-write-cancel controls.

## Interface
Parameters:
- `XLEN`, 32, datapath and CSR width.
- `NUM_IRQ`, 12, interrupt lines (1..32); line i has cause code i.
- `VECTORED_EN`, 1, honour `mtvec.MODE`=1 (vectored); 0 forces direct mode.
- `MTVAL_EN`, 1, write `mtval` during trap entry; 0 skips that state.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, synchronous and active-high.
- `exc_illegal_addr`, `exc_illegal_inst`, `exc_ebreak`, `exc_l_fault`, `exc_s_fault`, `exc_ecall` in 1 each: MEM-stage exception flags.
- `irq_pending` in NUM_IRQ: level interrupt requests (mip image).
- `csr_mie` in NUM_IRQ: interrupt enable bits.
- `csr_mstatus` in XLEN: current mstatus.
- `csr_mtvec` in XLEN: current mtvec.
- `csr_mepc` in XLEN: current mepc.
- `mret` in 1: MEM-stage mret.
- `epc_cur` in XLEN: PC of the faulting instruction.
- `epc_next` in XLEN: PC of the next instruction, used for interrupts.
- `bad_val` in XLEN: faulting address or instruction, used for mtval.
- `csr_we` out 1: trap write request to the CSR file; overrides pipeline CSR writes.
- `csr_waddr` out 12: trap write address.
- `csr_wdata` out XLEN: trap write data.
- `pc_redirect` out XLEN: redirect target.
- `redirect_valid` out 1: take `pc_redirect`.
- `flush_fd`, `flush_de`, `flush_em`, `flush_mw` out 1 each: pipeline register flushes.
- `regwrite_cancel` out 1: suppress WB of the faulting instruction.
- `busy` out 1: sequence in progress; stalls CSR instructions in the pipeline.

## Operation
- Trap request is `take_exc | take_irq`:
  - `take_exc` is the OR of all `exc_*` flags.
  - `take_irq` is `mstatus.MIE & |(irq_pending & csr_mie)`.
- Exceptions beat interrupts.
- Exception priority and cause codes:
  - illegal_addr, cause 0
  - illegal_inst, cause 2
  - ebreak, cause 3
  - l_fault, cause 5
  - s_fault, cause 7
  - ecall, cause 11
- Interrupts: the highest enabled index wins; cause = `{1'b1, index}` zero-extended to XLEN.
- States: `IDLE`, `W_MEPC`, `W_MCAUSE`, `W_MTVAL`, `REDIRECT`.
- IDLE with a trap request:
  - write mstatus with MPIE←MIE and MIE←0;
  - latch `epc_q`, `cause_q` and `tval_q`;
  - go to W_MEPC.
- Latched values:
  - `epc_q` is `epc_cur` for exceptions and `epc_next` for interrupts.
  - `tval_q` is `bad_val` for exceptions and 0 for interrupts.
- Sequence states:
  - W_MEPC writes `epc_q` to 0x341, then goes to W_MCAUSE.
  - W_MCAUSE writes `cause_q` to 0x342, then goes to W_MTVAL, or to REDIRECT when MTVAL_EN=0.
  - W_MTVAL writes `tval_q` to 0x343, then goes to REDIRECT.
  - REDIRECT has no CSR write; it asserts `redirect_valid` and returns to IDLE.
- Redirect target:
  - `{mtvec[XLEN-1:2],2'b00}`;
  - plus `4*index` only when VECTORED_EN=1, `mtvec[1:0]`=01, and the trap is an interrupt.
- IDLE with `mret` and no trap request, completed in one cycle with no state change:
  - write mstatus with MIE←MPIE and MPIE←1;
  - `pc_redirect=csr_mepc`, `redirect_valid=1`;
  - flush FD, DE and EM.
- Trap request and `mret` in the same cycle: the trap wins and the mret is discarded (it is flushed).
- Outside IDLE, all `exc_*`, `irq_pending` and `mret` are ignored. Pending interrupts are re-evaluated on return to IDLE, using the updated mstatus.
- `busy` = (state≠IDLE).

## Timing
- Trap detected in cycle T:
  - T: mstatus write;
  - T+1: mepc write;
  - T+2: mcause write;
  - T+3: mtval write;
  - T+4: redirect;
  - with MTVAL_EN=0, the redirect is at T+3.
- The first new fetch follows the redirect cycle.
- Flushes:
  - `flush_fd`: T through the redirect cycle, inclusive.
  - `flush_de` and `flush_em`: T only.
  - `flush_mw`: T only.
  - `regwrite_cancel`: T, for exceptions only.
- All outputs are combinational from the state and registers, plus IDLE-cycle inputs.
- Reset value (and value on `rst` mid-sequence):
  - state IDLE;
  - latched registers 0;
  - every output 0.
- A partially written CSR sequence is abandoned on reset; the CSR file resets independently.

## Structure
- Shared package `trap_pkg`:
  - CSR addresses (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343);
  - exception cause constants;
  - state enum;
  - mstatus bit indices (MIE=3, MPIE=7).
- Sub-module `trap_prio_enc`:
  - parametrised by `NUM_IRQ`;
  - inputs: masked pending vector;
  - outputs: `valid` and `$clog2(NUM_IRQ)` index, highest index first.

## Test plan
- `exc_illegal_inst` at T with `epc_cur`=0x100, `bad_val`=0x0000FFFF, `mtvec`=0x800:
  - writes mstatus (MIE 1→0, MPIE=1), then mepc 0x100, mcause 2, mtval 0xFFFF;
  - redirect 0x800 at T+4;
  - `regwrite_cancel` high at T only.
- `irq_pending[7]` and `irq_pending[11]` enabled, `mtvec`=0x801, VECTORED_EN=1, `epc_next`=0x204:
  - mcause 0x8000000B, mepc 0x204;
  - redirect 0x82C.
- `exc_ecall` and `irq_pending[11]` together: cause 11, `epc_cur` latched, no interrupt cause written.
- Interrupts with mstatus.MIE=0, or with `csr_mie`=0 for the pending line: no `csr_we`, no flush.
- `mret` with `csr_mepc`=0x104, MPIE=1: a single cycle with redirect 0x104, mstatus MIE=1, and FD/DE/EM flush; a same-cycle `exc_ebreak` yields a trap instead.
- `rst` asserted in W_MCAUSE: next cycle IDLE, all outputs 0; a new trap then runs the full sequence.
